// File: rtl/i3c_tx_serializer.sv
// I3C controller SDA transmit stage: serializes register-file bytes MSB first,
// or drives fixed/T-bit levels, advancing on SCL falling edges.
module i3c_tx_serializer #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_SDA   = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tx_en,
    input  logic [2:0]            i_tx_mode,
    input  logic [DATA_WIDTH-1:0] i_regf_data,
    input  logic                  i_scl_neg_edge,
    output logic                  o_sda,
    output logic                  o_tx_mode_done,
    output logic                  o_busy,
    output logic                  o_parity
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD
    } state_t;

    localparam logic [2:0] MODE_ONE    = 3'b000;
    localparam logic [2:0] MODE_SERIAL = 3'b001;
    localparam logic [2:0] MODE_ZERO   = 3'b010;
    localparam logic [2:0] MODE_TBIT   = 3'b011;

    state_t                state_q,  state_d;
    logic                  sda_q,    sda_d;
    logic                  done_q,   done_d;
    logic                  busy_q,   busy_d;
    logic                  parity_q, parity_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [2:0]            mode_q,   mode_d;
    logic [DATA_WIDTH-1:0] shreg_q,  shreg_d;
    logic                  level;

    // Static SDA level for every non-serial mode; reserved modes idle high.
    always_comb begin
        level = 1'b1;
        case (mode_q)
            MODE_ONE:  level = 1'b1;
            MODE_ZERO: level = 1'b0;
            MODE_TBIT: level = parity_q;
            default:   level = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: every next-state value starts from its current register value so
        // no path through the case leaves a variable unassigned (no latches).
        state_d  = state_q;
        sda_d    = sda_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        shreg_d  = shreg_q;

        case (state_q)
            S_IDLE: begin
                if (i_tx_en) begin
                    mode_d  = i_tx_mode;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (mode_q == MODE_SERIAL) begin
                    shreg_d  = i_regf_data;
                    sda_d    = i_regf_data[DATA_WIDTH-1];
                    idx_d    = IDX_MSB;
                    parity_d = ~^i_regf_data;
                    state_d  = S_SHIFT;
                end else begin
                    sda_d   = level;
                    state_d = S_HOLD;
                end
            end
            S_SHIFT: begin
                if (i_scl_neg_edge) begin
                    if (idx_q == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        shreg_d = shreg_q << 1;
                        sda_d   = shreg_q[DATA_WIDTH-2];
                    end
                end
            end
            S_HOLD: begin
                if (i_scl_neg_edge) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            sda_q    <= IDLE_SDA;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            parity_q <= 1'b1;
            idx_q    <= IDX_MSB;
            mode_q   <= MODE_ONE;
            shreg_q  <= '0;
        end else begin
            state_q  <= state_d;
            sda_q    <= sda_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            shreg_q  <= shreg_d;
        end
    end

    assign o_sda          = sda_q;
    assign o_tx_mode_done = done_q;
    assign o_busy         = busy_q;
    assign o_parity       = parity_q;

endmodule

// File: tb/tb_i3c_tx_serializer.sv
// Directed bench for i3c_tx_serializer: serial words, level modes, T-bit,
// ignored strobes/edges, reserved mode and mid-transfer reset.
module tb_i3c_tx_serializer;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_tx_en;
    logic [2:0] i_tx_mode;
    logic [7:0] i_regf_data;
    logic       i_scl_neg_edge;
    logic       o_sda;
    logic       o_tx_mode_done;
    logic       o_busy;
    logic       o_parity;

    int checks = 0;
    int errors = 0;

    i3c_tx_serializer #(.DATA_WIDTH(8), .IDLE_SDA(1'b1)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_tx_en        (i_tx_en),
        .i_tx_mode      (i_tx_mode),
        .i_regf_data    (i_regf_data),
        .i_scl_neg_edge (i_scl_neg_edge),
        .o_sda          (o_sda),
        .o_tx_mode_done (o_tx_mode_done),
        .o_busy         (o_busy),
        .o_parity       (o_parity)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic scl_edge();
        i_scl_neg_edge = 1'b1;
        tick();
        i_scl_neg_edge = 1'b0;
    endtask

    // Strobe i_tx_en for one cycle, present data in the LOAD cycle; returns after LOAD.
    task automatic start(input logic [2:0] mode, input logic [7:0] data);
        i_tx_en   = 1'b1;
        i_tx_mode = mode;
        tick();
        i_tx_en     = 1'b0;
        i_tx_mode   = 3'b000;
        i_regf_data = data;
        tick();
        i_regf_data = 8'h00;
    endtask

    task automatic send_word(input string tag, input logic [7:0] data, input logic exp_par);
        start(3'b001, data);
        check({tag, " msb"}, o_sda, data[7]);
        check({tag, " busy"}, o_busy, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check({tag, " hold between edges"}, o_sda, data[8-i]);
            scl_edge();
            check({tag, " bit"}, o_sda, data[7-i]);
            check({tag, " no early done"}, o_tx_mode_done, 1'b0);
        end
        scl_edge();
        check({tag, " done"}, o_tx_mode_done, 1'b1);
        check({tag, " busy off"}, o_busy, 1'b0);
        check({tag, " sda after done"}, o_sda, data[0]);
        tick();
        check({tag, " done one cycle"}, o_tx_mode_done, 1'b0);
        check({tag, " parity"}, o_parity, exp_par);
    endtask

    task automatic send_level(input string tag, input logic [2:0] mode, input logic exp_sda);
        start(mode, 8'hFF);
        check({tag, " level"}, o_sda, exp_sda);
        check({tag, " no done yet"}, o_tx_mode_done, 1'b0);
        tick();
        check({tag, " level held"}, o_sda, exp_sda);
        check({tag, " still waiting"}, o_tx_mode_done, 1'b0);
        scl_edge();
        check({tag, " done"}, o_tx_mode_done, 1'b1);
        check({tag, " busy off"}, o_busy, 1'b0);
        tick();
        check({tag, " done one cycle"}, o_tx_mode_done, 1'b0);
        check({tag, " sda kept in idle"}, o_sda, exp_sda);
    endtask

    initial begin
        i_rst_n        = 1'b0;
        i_tx_en        = 1'b0;
        i_tx_mode      = 3'b000;
        i_regf_data    = 8'h00;
        i_scl_neg_edge = 1'b0;

        // Reset values
        tick();
        tick();
        i_rst_n = 1'b1;
        check("reset sda", o_sda, 1'b1);
        check("reset busy", o_busy, 1'b0);
        check("reset done", o_tx_mode_done, 1'b0);
        check("reset parity", o_parity, 1'b1);
        tick();
        check("idle sda", o_sda, 1'b1);

        // 0xFC: 1,1,1,1,1,1,0,0 ; six ones -> T-bit 1
        send_word("w_fc", 8'hFC, 1'b1);

        // 0x20: 0,0,1,0,0,0,0,0 ; one one -> T-bit 0, then T-bit phase drives 0
        send_word("w_20", 8'h20, 1'b0);
        send_level("tbit_20", 3'b011, 1'b0);
        check("tbit keeps parity", o_parity, 1'b0);

        // Mode 010 then 000, parity untouched
        send_level("mode_010", 3'b010, 1'b0);
        check("mode_010 parity", o_parity, 1'b0);
        send_level("mode_000", 3'b000, 1'b1);
        check("mode_000 parity", o_parity, 1'b0);

        // 0xC2 with interference: edge with tx_en, edge in LOAD, second tx_en at bit 3
        i_tx_en        = 1'b1;
        i_tx_mode      = 3'b001;
        i_scl_neg_edge = 1'b1;
        tick();
        i_tx_en     = 1'b0;
        i_tx_mode   = 3'b000;
        i_regf_data = 8'hC2;
        tick();
        i_scl_neg_edge = 1'b0;
        i_regf_data    = 8'h00;
        check("intf msb after load", o_sda, 1'b1);
        check("intf busy", o_busy, 1'b1);
        scl_edge(); check("intf bit6", o_sda, 1'b1);
        scl_edge(); check("intf bit5", o_sda, 1'b0);
        scl_edge(); check("intf bit4", o_sda, 1'b0);
        scl_edge(); check("intf bit3", o_sda, 1'b0);
        i_tx_en   = 1'b1;
        i_tx_mode = 3'b010;
        tick();
        i_tx_en   = 1'b0;
        i_tx_mode = 3'b000;
        check("intf restrobe ignored sda", o_sda, 1'b0);
        check("intf restrobe busy", o_busy, 1'b1);
        tick();
        check("intf restrobe no done", o_tx_mode_done, 1'b0);
        scl_edge(); check("intf bit2", o_sda, 1'b0);
        scl_edge(); check("intf bit1", o_sda, 1'b1);
        scl_edge(); check("intf bit0", o_sda, 1'b0);
        check("intf no done at 7", o_tx_mode_done, 1'b0);
        scl_edge();
        check("intf done at 8", o_tx_mode_done, 1'b1);
        tick();
        check("intf done one cycle", o_tx_mode_done, 1'b0);
        check("intf parity", o_parity, 1'b0);

        // Reserved 101 drives 1 from a low idle level, parity kept at 0
        send_level("rsv_101", 3'b101, 1'b1);
        check("rsv parity", o_parity, 1'b0);
        check("rsv idle busy", o_busy, 1'b0);

        // Reset mid-SHIFT of 0xA5 (1,0,1,0,...)
        start(3'b001, 8'hA5);
        scl_edge();
        scl_edge();
        scl_edge();
        check("pre-reset bit4", o_sda, 1'b0);
        i_rst_n = 1'b0;
        tick();
        check("in-reset done", o_tx_mode_done, 1'b0);
        tick();
        i_rst_n = 1'b1;
        check("post-reset sda", o_sda, 1'b1);
        check("post-reset busy", o_busy, 1'b0);
        check("post-reset parity", o_parity, 1'b1);
        check("post-reset done", o_tx_mode_done, 1'b0);
        for (int i = 0; i < 6; i++) begin
            scl_edge();
            check("idle edge no done", o_tx_mode_done, 1'b0);
            check("idle edge sda", o_sda, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
